sw_core_arbiter: RTL and testbench
==================================

Name: sw_core_arbiter

Overview:
Shares one SW_core (Smith-Waterman alignment engine) between two independent requesters, e.g. the UART-fed wrapper and a second host path.
- Round-robin grant; one alignment in flight at a time.
- Validates sequence lengths, enforces a response watchdog, and routes each result to its owner.
- Sits between requester front-ends and the SW_core valid/ready ports.

Parameters:
SEQ_W, 256, packed sequence width (128 bases x 2 bits)
LEN_W, 8, sequence length field width
MAX_LEN, 128, largest legal sequence length
SCORE_W, 10, alignment score width (DP_SW_SCORE_BITWIDTH)
POS_W, 7, row/column index width
TIMEOUT, 4096, cycles allowed in S_WAIT before an error response is returned

Ports:
avm_clk in 1 clock; one clock domain
avm_rst in 1 reset; synchronous, active-high
reqN_valid in 1 request from requester N (N=0,1)
reqN_ready out 1 request accepted this cycle
reqN_ref in SEQ_W reference sequence
reqN_read in SEQ_W read sequence
reqN_ref_len in LEN_W reference length
reqN_read_len in LEN_W read length
rspN_valid out 1 result for requester N
rspN_ready in 1 requester N consumes result
rspN_score out SCORE_W alignment score
rspN_column out POS_W best-cell column
rspN_row out POS_W best-cell row
rspN_err out 1 1 = length error or timeout
core_valid out 1 to SW_core i_valid
core_ready in 1 from SW_core o_ready
core_ref, core_read out SEQ_W to i_sequence_ref, i_sequence_read
core_ref_len, core_read_len out LEN_W to i_seq_ref_length, i_seq_read_length
core_rsp_ready out 1 to SW_core i_ready
core_rsp_valid in 1 from SW_core o_valid
core_score in SCORE_W; core_column, core_row in POS_W
busy out 1 state != S_IDLE or stale_r set
job_count out 16 completed non-error jobs; wraps 65535->0

Behaviour:
- Reset (sync, high): state S_IDLE; last_grant=1, so req0 wins first; stale_r=0; timer=0; job_count=0.
- Reset also clears every output and the latched job and response registers to 0. It takes effect mid-operation; the SW_core shares avm_rst.
- S_IDLE:
  - If stale_r=0 and any reqN_valid, pick one: when both are valid, grant the requester != last_grant.
  - reqN_ready is asserted combinationally in S_IDLE for the picked N only. Handshake completes on valid&&ready.
  - On accept: latch the fields and owner=N; last_grant<=N.
  - If either length is 0 or >MAX_LEN: go to S_RESP with err=1, score/col/row=0. No core traffic.
  - Otherwise go to S_ISSUE.
- S_ISSUE: core_valid=1 with latched fields held stable. On core_ready, go to S_WAIT and set timer=0.
- S_WAIT:
  - core_rsp_ready=1 and timer increments each cycle.
  - On core_rsp_valid: latch score/column/row, err=0, go to S_RESP.
  - If timer==TIMEOUT-1 with no valid: go to S_RESP with err=1, fields 0, and set stale_r=1.
  - If both occur in the same cycle, the valid wins; stale_r is not set.
- S_RESP:
  - rsp{owner}_valid=1, other requester's rsp valid=0; fields held stable until rsp{owner}_ready.
  - On handshake: go to S_IDLE; job_count++ if err=0.
  - Requests are not granted while in S_RESP.
- Stale drain:
  - While stale_r=1, core_rsp_ready=1 in every state other than S_WAIT.
  - The next core_rsp_valid is discarded and clears stale_r.
  - No grant occurs while stale_r=1.
- Latency with no backpressure: accept -> core_valid at +1 cycle. core_rsp_valid -> rsp valid at +1 cycle. Length error -> rsp valid at +1 cycle.
- Requesters must hold valid and fields until ready. This is a protocol rule, not checked in RTL.

Decomposition:
- sw_pkg holds:
  - width constants (SEQ_W, LEN_W, SCORE_W, POS_W, MAX_LEN);
  - score constants (match 1, mismatch -4, gap open -6, gap extend -1);
  - the state enum typedef (S_IDLE, S_ISSUE, S_WAIT, S_RESP);
  - a packed job struct and a packed result struct.
- One sub-module: sw_rr_pick2, a 2-way round-robin picker. Inputs: two valids and last_grant. Outputs: grant_valid and grant_id.

Test Plan:
- req0 alone with ref_len=4, read_len=4; core model returns score 4, col 3, row 3 after 10 cycles -> rsp0_valid, score 4/3/3, err 0, job_count=1, rsp1_valid never high.
- req0 and req1 valid in the same cycle after reset -> req0 granted first, req1 second. Repeat both valid -> grants alternate 0,1,0,1.
- req1 ref_len=0 -> req1_ready for 1 cycle, core_valid never asserted, rsp1_valid next cycle with err=1, score 0, job_count unchanged.
- TIMEOUT=16, core never responds -> rsp0 err=1 after 16 cycles in S_WAIT. Late core_rsp_valid is discarded; a pending req1 is granted only after the discard.
- rsp0_ready held low 5 cycles while req1_valid=1 -> rsp0 fields stable, req1_ready stays 0 until the handshake.
- avm_rst pulsed for 1 cycle in S_WAIT -> next cycle: all outputs 0, busy=0, job_count=0; next request is granted to req0.

Source files
------------

// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sw_pkg
// Description : Shared widths, scoring constants, FSM states and job/result
//               records for the Smith-Waterman core arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

    localparam int SEQ_W   = 256;
    localparam int LEN_W   = 8;
    localparam int MAX_LEN = 128;
    localparam int SCORE_W = 10;
    localparam int POS_W   = 7;

    localparam int signed MATCH_SCORE      = 1;
    localparam int signed MISMATCH_SCORE   = -4;
    localparam int signed GAP_OPEN_SCORE   = -6;
    localparam int signed GAP_EXTEND_SCORE = -1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [SEQ_W-1:0] ref_seq;
        logic [SEQ_W-1:0] read_seq;
        logic [LEN_W-1:0] ref_len;
        logic [LEN_W-1:0] read_len;
    } job_t;

    typedef struct packed {
        logic [SCORE_W-1:0] score;
        logic [POS_W-1:0]   column;
        logic [POS_W-1:0]   row;
        logic               err;
    } result_t;

    function automatic logic len_bad(input logic [LEN_W-1:0] len);
        return (len == '0) || (len > LEN_W'(MAX_LEN));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : sw_rr_pick2
// Description : Two-way round-robin picker; on contention the requester that
//               was not granted last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_rr_pick2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    logic w_both;

    assign w_both      = valid0 & valid1;
    assign grant_valid = valid0 | valid1;
    assign grant_id    = w_both ? ~last_grant : valid1;

endmodule
`default_nettype wire

// File: rtl/sw_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sw_core_arbiter
// Description : Shares one SW_core between two requesters with round-robin
//               grant, length checking, response watchdog and result routing.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_core_arbiter
    import sw_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic               avm_clk,
    input  logic               avm_rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [SEQ_W-1:0]   req0_ref,
    input  logic [SEQ_W-1:0]   req0_read,
    input  logic [LEN_W-1:0]   req0_ref_len,
    input  logic [LEN_W-1:0]   req0_read_len,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [SEQ_W-1:0]   req1_ref,
    input  logic [SEQ_W-1:0]   req1_read,
    input  logic [LEN_W-1:0]   req1_ref_len,
    input  logic [LEN_W-1:0]   req1_read_len,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [SCORE_W-1:0] rsp0_score,
    output logic [POS_W-1:0]   rsp0_column,
    output logic [POS_W-1:0]   rsp0_row,
    output logic               rsp0_err,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [SCORE_W-1:0] rsp1_score,
    output logic [POS_W-1:0]   rsp1_column,
    output logic [POS_W-1:0]   rsp1_row,
    output logic               rsp1_err,
    output logic               core_valid,
    input  logic               core_ready,
    output logic [SEQ_W-1:0]   core_ref,
    output logic [SEQ_W-1:0]   core_read,
    output logic [LEN_W-1:0]   core_ref_len,
    output logic [LEN_W-1:0]   core_read_len,
    output logic               core_rsp_ready,
    input  logic               core_rsp_valid,
    input  logic [SCORE_W-1:0] core_score,
    input  logic [POS_W-1:0]   core_column,
    input  logic [POS_W-1:0]   core_row,
    output logic               busy,
    output logic [15:0]        job_count
);

    localparam int C_TMR_W = $clog2(TIMEOUT);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic               r_stale;
    logic [C_TMR_W-1:0] r_timer;
    logic [15:0]        r_job_count;
    job_t               r_job;
    logic               r_owner;
    result_t            r_res;

    logic w_grant_valid;
    logic w_grant_id;
    logic w_len_err;
    logic w_timeout;
    logic w_rsp_fire;
    job_t w_pick_job;

    sw_rr_pick2 u_pick (
        .valid0      (r_state == S_IDLE && !r_stale && req0_valid),
        .valid1      (r_state == S_IDLE && !r_stale && req1_valid),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    assign w_pick_job = w_grant_id ? job_t'{req1_ref, req1_read, req1_ref_len, req1_read_len}
                                   : job_t'{req0_ref, req0_read, req0_ref_len, req0_read_len};
    assign w_len_err  = len_bad(w_pick_job.ref_len) || len_bad(w_pick_job.read_len);
    assign w_timeout  = (r_timer == C_TMR_W'(TIMEOUT - 1));
    assign w_rsp_fire = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);

    always_ff @(posedge avm_clk) begin
        if (avm_rst) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_valid) w_next_state = w_len_err ? S_RESP : S_ISSUE;
            S_ISSUE: if (core_ready) w_next_state = S_WAIT;
            S_WAIT:  if (core_rsp_valid || w_timeout) w_next_state = S_RESP;
            S_RESP:  if (w_rsp_fire) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready     = w_grant_valid && !w_grant_id;
        req1_ready     = w_grant_valid &&  w_grant_id;
        core_valid     = (r_state == S_ISSUE);
        core_rsp_ready = (r_state == S_WAIT) || r_stale;
        rsp0_valid     = (r_state == S_RESP) && !r_owner;
        rsp1_valid     = (r_state == S_RESP) &&  r_owner;
        busy           = (r_state != S_IDLE) || r_stale;
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            r_last_grant <= 1'b1;
            r_stale      <= 1'b0;
            r_timer      <= '0;
            r_job_count  <= '0;
            r_job        <= '0;
            r_owner      <= 1'b0;
            r_res        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_job        <= w_pick_job;
                        r_owner      <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_res        <= '0;
                        r_res.err    <= w_len_err;
                    end
                end
                S_ISSUE: begin
                    if (core_ready) r_timer <= '0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + C_TMR_W'(1);
                    // A response arriving on the deadline cycle still counts as on time.
                    if (core_rsp_valid) begin
                        r_res <= result_t'{core_score, core_column, core_row, 1'b0};
                    end else if (w_timeout) begin
                        r_res     <= '0;
                        r_res.err <= 1'b1;
                        r_stale   <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_fire && !r_res.err) r_job_count <= r_job_count + 16'd1;
                end
                default: ;
            endcase
            // The late answer to a timed-out job is swallowed outside S_WAIT.
            if (r_stale && r_state != S_WAIT && core_rsp_valid) r_stale <= 1'b0;
        end
    end

    assign core_ref      = r_job.ref_seq;
    assign core_read     = r_job.read_seq;
    assign core_ref_len  = r_job.ref_len;
    assign core_read_len = r_job.read_len;
    assign rsp0_score    = r_res.score;
    assign rsp0_column   = r_res.column;
    assign rsp0_row      = r_res.row;
    assign rsp0_err      = r_res.err;
    assign rsp1_score    = r_res.score;
    assign rsp1_column   = r_res.column;
    assign rsp1_row      = r_res.row;
    assign rsp1_err      = r_res.err;
    assign job_count     = r_job_count;

endmodule
`default_nettype wire

// File: tb/tb_sw_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_core_arbiter
// Description : Transaction-level self-checking bench for sw_core_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_core_arbiter;

    localparam int TMO = 16;

    logic         avm_clk = 1'b0;
    logic         avm_rst = 1'b1;
    logic         req0_valid = 0, req1_valid = 0;
    logic         req0_ready, req1_ready;
    logic [255:0] req0_ref = '0, req0_read = '0, req1_ref = '0, req1_read = '0;
    logic [7:0]   req0_ref_len = '0, req0_read_len = '0, req1_ref_len = '0, req1_read_len = '0;
    logic         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic         rsp0_ready = 0, rsp1_ready = 0;
    logic [9:0]   rsp0_score, rsp1_score;
    logic [6:0]   rsp0_column, rsp0_row, rsp1_column, rsp1_row;
    logic         core_valid, core_rsp_ready;
    logic         core_ready = 0, core_rsp_valid = 0;
    logic [255:0] core_ref, core_read;
    logic [7:0]   core_ref_len, core_read_len;
    logic [9:0]   core_score = '0;
    logic [6:0]   core_column = '0, core_row = '0;
    logic         busy;
    logic [15:0]  job_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: who was granted last, completed jobs, pending late answer.
    int         exp_last  = 1;
    int         exp_jobs  = 0;
    bit         exp_stale = 0;

    sw_core_arbiter #(.TIMEOUT(TMO)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ref(req0_ref), .req0_read(req0_read),
        .req0_ref_len(req0_ref_len), .req0_read_len(req0_read_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ref(req1_ref), .req1_read(req1_read),
        .req1_ref_len(req1_ref_len), .req1_read_len(req1_read_len),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_score(rsp0_score),
        .rsp0_column(rsp0_column), .rsp0_row(rsp0_row), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_score(rsp1_score),
        .rsp1_column(rsp1_column), .rsp1_row(rsp1_row), .rsp1_err(rsp1_err),
        .core_valid(core_valid), .core_ready(core_ready), .core_ref(core_ref), .core_read(core_read),
        .core_ref_len(core_ref_len), .core_read_len(core_read_len),
        .core_rsp_ready(core_rsp_ready), .core_rsp_valid(core_rsp_valid),
        .core_score(core_score), .core_column(core_column), .core_row(core_row),
        .busy(busy), .job_count(job_count)
    );

    always #5 avm_clk = ~avm_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge avm_clk);
        #1;
    endtask

    function automatic logic [255:0] rand_seq();
        logic [255:0] s;
        for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic rsp_v(input int n);
        return (n != 0) ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [24:0] rsp_fields(input int n);
        return (n != 0) ? {rsp1_score, rsp1_column, rsp1_row, rsp1_err}
                        : {rsp0_score, rsp0_column, rsp0_row, rsp0_err};
    endfunction

    function automatic logic req_rdy(input int n);
        return (n != 0) ? req1_ready : req0_ready;
    endfunction

    function automatic bool_len_bad(input logic [7:0] len);
        return (len == 0) || (len > 8'd128);
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_req_ready"}, {req0_ready, req1_ready}, 0);
        check({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 0);
        check({tag, "_rsp0"}, rsp_fields(0), 0);
        check({tag, "_core_valid"}, {core_valid, core_rsp_ready}, 0);
        check({tag, "_core_job"}, (core_ref === '0 && core_read === '0 &&
                                   core_ref_len === '0 && core_read_len === '0), 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_job_count"}, job_count, 0);
    endtask

    // One complete transaction. core_delay >= TMO means the core never answers.
    task automatic run_job(input bit v0, input bit v1,
                           input logic [7:0] rl0, input logic [7:0] dl0,
                           input logic [7:0] rl1, input logic [7:0] dl1,
                           input int core_delay, input int rsp_stall,
                           input logic [9:0] sc, input logic [6:0] col, input logic [6:0] row);
        int           w, l;
        bit           err;
        int           stall;
        logic [255:0] wref, wread;
        logic [7:0]   wrl, wdl;
        logic [24:0]  exp_rsp;

        req0_ref = rand_seq(); req0_read = rand_seq(); req0_ref_len = rl0; req0_read_len = dl0;
        req1_ref = rand_seq(); req1_read = rand_seq(); req1_ref_len = rl1; req1_read_len = dl1;
        req0_valid = v0; req1_valid = v1;
        w = (v0 && v1) ? (exp_last == 1 ? 0 : 1) : (v1 ? 1 : 0);
        l = 1 - w;
        #1;

        if (exp_stale) begin
            for (int i = 0; i < 3; i++) begin
                check("stale_no_grant", {req0_ready, req1_ready}, 0);
                check("stale_busy", busy, 1);
                check("stale_core_rsp_ready", core_rsp_ready, 1);
                tick();
            end
            core_score = 10'h3ff; core_rsp_valid = 1'b1;
            tick();
            core_rsp_valid = 1'b0;
            exp_stale = 0;
            #1;
        end

        check("grant_ready0", req0_ready, (w == 0));
        check("grant_ready1", req1_ready, (w == 1));
        wref = w ? req1_ref : req0_ref;
        wread = w ? req1_read : req0_read;
        wrl = w ? rl1 : rl0;
        wdl = w ? dl1 : dl0;
        err = bool_len_bad(wrl) || bool_len_bad(wdl);
        tick();
        exp_last = w;
        if (w == 0) req0_valid = 0; else req1_valid = 0;

        if (err) begin
            exp_rsp = {10'd0, 7'd0, 7'd0, 1'b1};
            check("lenerr_no_core", core_valid, 0);
        end else begin
            stall = $urandom_range(0, 2);
            for (int i = 0; i <= stall; i++) begin
                check("issue_core_valid", core_valid, 1);
                check("issue_fields", (core_ref === wref && core_read === wread &&
                                       core_ref_len === wrl && core_read_len === wdl), 1);
                check("issue_loser_ready", req_rdy(l), 0);
                if (i == stall) core_ready = 1'b1;
                tick();
            end
            core_ready = 1'b0;
            check("wait_core_rsp_ready", {core_valid, core_rsp_ready}, 2'b01);
            if (core_delay < TMO) begin
                for (int i = 0; i < core_delay; i++) begin
                    check("wait_no_rsp", {rsp0_valid, rsp1_valid}, 0);
                    tick();
                end
                core_score = sc; core_column = col; core_row = row; core_rsp_valid = 1'b1;
                tick();
                core_rsp_valid = 1'b0;
                exp_rsp = {sc, col, row, 1'b0};
            end else begin
                for (int i = 0; i < TMO; i++) begin
                    check("wait_no_rsp", {rsp0_valid, rsp1_valid}, 0);
                    tick();
                end
                exp_rsp = {10'd0, 7'd0, 7'd0, 1'b1};
                exp_stale = 1;
            end
        end

        for (int i = 0; i <= rsp_stall; i++) begin
            check("rsp_valid_owner", rsp_v(w), 1);
            check("rsp_valid_other", rsp_v(l), 0);
            check("rsp_fields", rsp_fields(w), exp_rsp);
            check("rsp_loser_ready", req_rdy(l), 0);
            check("rsp_core_rsp_ready", core_rsp_ready, exp_stale);
            if (i == rsp_stall) begin
                if (w == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            end
            tick();
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        if (!exp_rsp[0]) exp_jobs = (exp_jobs + 1) % 65536;
        check("done_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("done_job_count", job_count, exp_jobs);
        check("done_busy", busy, exp_stale);
        req0_valid = 0; req1_valid = 0;
    endtask

    function automatic logic [7:0] rand_len();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'(129 + $urandom_range(0, 126));
        return 8'($urandom_range(1, 128));
    endfunction

    initial begin
        tick(); tick();
        avm_rst = 1'b0;
        #1;
        check_idle_zero("reset");

        // Single job on requester 0, answered 10 cycles into the wait.
        run_job(1, 0, 8'd4, 8'd4, 8'd0, 8'd0, 10, 0, 10'd4, 7'd3, 7'd3);
        check("first_job_count", job_count, 1);
        // Contention alternates grants.
        for (int i = 0; i < 4; i++)
            run_job(1, 1, 8'd10, 8'd20, 8'd30, 8'd40, i, 0, 10'(i + 7), 7'(i), 7'(i + 1));
        // Zero length on requester 1.
        run_job(0, 1, 8'd5, 8'd5, 8'd0, 8'd9, 0, 0, 10'd0, 7'd0, 7'd0);
        // Length boundaries: 128 legal, 129 rejected.
        run_job(1, 0, 8'd128, 8'd128, 8'd0, 8'd0, 2, 0, 10'd99, 7'd127, 7'd127);
        run_job(1, 0, 8'd129, 8'd1, 8'd0, 8'd0, 2, 0, 10'd0, 7'd0, 7'd0);
        // Response arriving on the deadline cycle, then a real timeout and drain.
        run_job(1, 0, 8'd3, 8'd3, 8'd0, 8'd0, TMO - 1, 0, 10'd12, 7'd2, 7'd1);
        run_job(1, 0, 8'd3, 8'd3, 8'd0, 8'd0, TMO, 0, 10'd0, 7'd0, 7'd0);
        run_job(0, 1, 8'd0, 8'd0, 8'd7, 8'd7, 1, 0, 10'd33, 7'd6, 7'd6);
        // Response backpressure with the other requester waiting.
        run_job(1, 1, 8'd6, 8'd6, 8'd6, 8'd6, 3, 5, 10'd55, 7'd5, 7'd4);

        for (int n = 0; n < 40; n++) begin
            bit v0, v1;
            int d;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            d = ($urandom_range(0, 5) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
            run_job(v0, v1, rand_len(), rand_len(), rand_len(), rand_len(), d,
                    int'($urandom_range(0, 3)), 10'($urandom), 7'($urandom), 7'($urandom));
        end

        // Drain any outstanding stale answer, then reset in the middle of a wait.
        run_job(1, 0, 8'd2, 8'd2, 8'd0, 8'd0, 0, 0, 10'd1, 7'd1, 7'd1);
        req0_ref = rand_seq(); req0_ref_len = 8'd8; req0_read_len = 8'd8; req0_valid = 1'b1;
        #1;
        check("prerst_grant", req0_ready, 1);
        tick();
        req0_valid = 1'b0; core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        tick(); tick();
        check("prerst_in_wait", {busy, core_rsp_ready}, 2'b11);
        avm_rst = 1'b1;
        tick();
        avm_rst = 1'b0;
        #1;
        check_idle_zero("midrst");
        exp_last = 1; exp_jobs = 0; exp_stale = 0;
        run_job(1, 1, 8'd4, 8'd4, 8'd4, 8'd4, 2, 0, 10'd8, 7'd3, 7'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
